// File: rtl/ps2_keymap.sv
// -----------------------------------------------------------------------------
// ps2_keymap
//
// Programmable PS/2 key-event to arcade-button mapper. Key events from the
// hps_io ps2_key bus are edge-detected on the toggle bit, queued in a small
// FIFO, then matched one map entry per cycle against a runtime-loadable table.
// Every matching entry drives its button bit, with a per-button minimum pulse
// width so very short taps are still seen by the core.
//
// Parameters
//   NUM_BTN    : number of buttons / map entries (2..64)
//   FIFO_DEPTH : key-event queue depth (power of 2, >= 2)
//   MIN_PULSE  : minimum cycles a button stays asserted once pressed (>= 1)
//
// Ports
//   clk_sys   in  : system clock, rising edge
//   reset_n   in  : asynchronous active-low reset
//   ps2_key   in  : [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   map_we    in  : map table write strobe
//   map_idx   in  : map entry to write
//   map_entry in  : [10] valid, [9] wild, [8] extended, [7:0] code
//   clear_all in  : synchronous release-all / flush (map table kept)
//   btn       out : button state, bit k driven by map entry k
//   busy      out : FIFO non-empty or scan in progress (registered)
//   overflow  out : sticky, a key event was dropped on a full FIFO
//
// Build option
//   KEYMAP_WILDCARD_EN : when defined, an entry's wild bit makes the match
//                        ignore the extended bit; otherwise wild is stored
//                        but has no effect.
// -----------------------------------------------------------------------------
module ps2_keymap #(
   parameter int NUM_BTN    = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_PULSE  = 16
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic [10:0]                ps2_key,
   input  logic                       map_we,
   input  logic [$clog2(NUM_BTN)-1:0] map_idx,
   input  logic [10:0]                map_entry,
   input  logic                       clear_all,
   output logic [NUM_BTN-1:0]         btn,
   output logic                       busy,
   output logic                       overflow
);

   localparam int IDX_W = $clog2(NUM_BTN);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BTN - 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MIN_PULSE - 1);
   localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   typedef struct packed {
      logic       valid;
      logic       wild;
      logic       ext;
      logic [7:0] code;
   } map_entry_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Toggle edge detect. The first edge after reset only primes old_tog so a
   // stale toggle level left over from before reset is never taken as an event.
   // ---------------------------------------------------------------------------
   logic     primed;
   logic     old_tog;
   logic     evt_fire;
   key_evt_t evt_in;

   assign evt_in   = key_evt_t'(ps2_key[9:0]);
   assign evt_fire = primed && (ps2_key[10] != old_tog);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed  <= 1'b0;
         old_tog <= 1'b0;
      end else begin
         primed  <= 1'b1;
         old_tog <= ps2_key[10];
      end
   end

   // ---------------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------------
   key_evt_t         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fifo_cnt;
   logic [PTR_W:0]   fifo_cnt_nxt;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FIFO_FULL);
   // A full FIFO still accepts the push when the head leaves on the same edge.
   assign push       = evt_fire && !clear_all && (!fifo_full || pop);

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      fifo_cnt_nxt = fifo_cnt;
      if (clear_all)
         fifo_cnt_nxt = '0;
      else if (push && !pop)
         fifo_cnt_nxt = fifo_cnt + (PTR_W + 1)'(1);
      else if (pop && !push)
         fifo_cnt_nxt = fifo_cnt - (PTR_W + 1)'(1);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         fifo_cnt <= fifo_cnt_nxt;
         if (clear_all) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (evt_fire && !push)
               overflow <= 1'b1;
         end
      end
   end

   // NOTE: the FIFO storage has no reset; the pointers and count alone define
   // which slots hold valid data, so clearing the array would buy nothing.
   always_ff @(posedge clk_sys) begin
      if (push)
         fifo_mem[wr_ptr] <= evt_in;
   end

   // ---------------------------------------------------------------------------
   // Map table. Compares read the registered entry, so a write to the entry
   // being compared on the same edge takes effect only for later scans.
   // ---------------------------------------------------------------------------
   map_entry_t map_tbl [NUM_BTN];
   logic       map_wr_ok;

   assign map_wr_ok = map_we && ({1'b0, map_idx} < (IDX_W + 1)'(NUM_BTN));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BTN; i++)
            map_tbl[i] <= '0;
      end else if (map_wr_ok) begin
         map_tbl[map_idx] <= map_entry_t'(map_entry);
      end
   end

   // ---------------------------------------------------------------------------
   // Scan FSM: IDLE pops one event, SCAN visits every entry once.
   // ---------------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   key_evt_t         cur;
   logic             scan_en;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (!fifo_empty)      state_nxt = S_SCAN;
         S_SCAN: if (idx == LAST_IDX)  state_nxt = S_IDLE;
      endcase
      if (clear_all)
         state_nxt = S_IDLE;
   end

   always_comb begin
      pop     = 1'b0;
      scan_en = 1'b0;
      case (state)
         S_IDLE: pop     = !fifo_empty && !clear_all;
         S_SCAN: scan_en = !clear_all;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         idx <= '0;
         cur <= '0;
      end else if (pop) begin
         idx <= '0;
         cur <= fifo_mem[rd_ptr];
      end else if (scan_en) begin
         idx <= idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         busy <= 1'b0;
      else
         busy <= (fifo_cnt_nxt != '0) || (state_nxt == S_SCAN);
   end

   // ---------------------------------------------------------------------------
   // Entry match
   // ---------------------------------------------------------------------------
   map_entry_t         ent;
   logic               ext_ok;
   logic               hit;
   logic [NUM_BTN-1:0] apply_vec;

   assign ent = map_tbl[idx];

`ifdef KEYMAP_WILDCARD_EN
   assign ext_ok = ent.wild || (ent.ext == cur.ext);
`else
   logic unused_wild;
   assign unused_wild = ent.wild;
   assign ext_ok      = (ent.ext == cur.ext);
`endif

   assign hit = scan_en && ent.valid && (ent.code == cur.code) && ext_ok;

   always_comb begin
      apply_vec = '0;
      if (hit)
         apply_vec[idx] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Button bank with minimum pulse width. A release that arrives while the
   // counter is still running is parked in rel_pend and applied when the
   // counter has reached zero; a new press cancels it.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0]   cnt [NUM_BTN];
   logic [NUM_BTN-1:0] rel_pend;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         btn      <= '0;
         rel_pend <= '0;
         for (int k = 0; k < NUM_BTN; k++)
            cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_BTN; k++) begin
            if (clear_all) begin
               btn[k]      <= 1'b0;
               rel_pend[k] <= 1'b0;
               cnt[k]      <= '0;
            end else if (apply_vec[k] && cur.pressed) begin
               btn[k]      <= 1'b1;
               rel_pend[k] <= 1'b0;
               cnt[k]      <= CNT_RELOAD;
            end else begin
               if (cnt[k] != '0)
                  cnt[k] <= cnt[k] - CNT_W'(1);
               if (apply_vec[k]) begin
                  if (cnt[k] == '0) begin
                     btn[k]      <= 1'b0;
                     rel_pend[k] <= 1'b0;
                  end else begin
                     rel_pend[k] <= 1'b1;
                  end
               end else if (rel_pend[k] && (cnt[k] == '0)) begin
                  btn[k]      <= 1'b0;
                  rel_pend[k] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
